// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multiply/divide controller owning the HI/LO register pair.
// Sequences multi-cycle MULT/MULTU/DIV/DIVU and single-cycle MTHI/MTLO,
// and raises a stall request while an operation is in flight.
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rd_sel,
    input  logic        md_use,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] dout
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;
    logic [31:0]     r_pend_hi;
    logic [31:0]     r_pend_lo;
    logic            r_pend_valid;

    // Operand views used by the arithmetic datapath
    logic signed [63:0] w_sa64;
    logic signed [63:0] w_sb64;
    logic signed [63:0] w_smul;
    logic        [63:0] w_umul;
    logic               w_div_ovf;
    logic               w_div_safe_sel;
    logic        [31:0] w_div_b;
    logic signed [31:0] w_sa;
    logic signed [31:0] w_sdb;
    logic signed [31:0] w_sq;
    logic signed [31:0] w_sr;
    logic        [31:0] w_uq;
    logic        [31:0] w_ur;
    logic        [31:0] w_res_hi;
    logic        [31:0] w_res_lo;
    logic               w_res_valid;

    assign w_sa64 = {{32{A[31]}}, A};
    assign w_sb64 = {{32{B[31]}}, B};
    assign w_smul = w_sa64 * w_sb64;
    assign w_umul = {32'd0, A} * {32'd0, B};

    // The most-negative / -1 case overflows the signed divider, and a zero
    // divisor has no result; both are steered to a harmless divisor of 1 and
    // resolved explicitly below.
    assign w_div_ovf      = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign w_div_safe_sel = (B == 32'd0) || w_div_ovf;
    assign w_div_b        = w_div_safe_sel ? 32'd1 : B;
    assign w_sa           = $signed(A);
    assign w_sdb          = $signed(w_div_b);
    assign w_sq           = w_sa / w_sdb;
    assign w_sr           = w_sa % w_sdb;
    assign w_uq           = A / w_div_b;
    assign w_ur           = A % w_div_b;

    // Select the 64-bit result and whether it will be committed to HI/LO
    always_comb begin
        w_res_hi    = 32'd0;
        w_res_lo    = 32'd0;
        w_res_valid = 1'b0;
        case (op)
            3'd0: begin
                w_res_hi    = w_smul[63:32];
                w_res_lo    = w_smul[31:0];
                w_res_valid = 1'b1;
            end
            3'd1: begin
                w_res_hi    = w_umul[63:32];
                w_res_lo    = w_umul[31:0];
                w_res_valid = 1'b1;
            end
            3'd2: begin
                if (B == 32'd0) begin
                    w_res_valid = 1'b0;
                end else if (w_div_ovf) begin
                    w_res_hi    = 32'd0;
                    w_res_lo    = 32'h8000_0000;
                    w_res_valid = 1'b1;
                end else begin
                    w_res_hi    = w_sr;
                    w_res_lo    = w_sq;
                    w_res_valid = 1'b1;
                end
            end
            3'd3: begin
                if (B == 32'd0) begin
                    w_res_valid = 1'b0;
                end else begin
                    w_res_hi    = w_ur;
                    w_res_lo    = w_uq;
                    w_res_valid = 1'b1;
                end
            end
            default: begin
                w_res_valid = 1'b0;
            end
        endcase
    end

    // Control FSM: accepts operations in IDLE, counts down in RUN, commits HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_hi         <= 32'd0;
            r_lo         <= 32'd0;
            r_pend_hi    <= 32'd0;
            r_pend_lo    <= 32'd0;
            r_pend_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            3'd0, 3'd1: begin
                                r_pend_hi    <= w_res_hi;
                                r_pend_lo    <= w_res_lo;
                                r_pend_valid <= w_res_valid;
                                r_cnt        <= CW'(MULT_CYCLES);
                                r_state      <= ST_RUN;
                            end
                            3'd2, 3'd3: begin
                                r_pend_hi    <= w_res_hi;
                                r_pend_lo    <= w_res_lo;
                                r_pend_valid <= w_res_valid;
                                r_cnt        <= CW'(DIV_CYCLES);
                                r_state      <= ST_RUN;
                            end
                            3'd4: begin
                                r_hi <= A;
                            end
                            3'd5: begin
                                r_lo <= A;
                            end
                            default: begin
                                r_state <= ST_IDLE;
                            end
                        endcase
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // New requests are ignored while an operation is in flight
                    if (r_cnt == CW'(1)) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        if (r_pend_valid) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end else begin
                            r_hi <= r_hi;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign busy     = (r_state == ST_RUN);
    assign md_stall = md_use & (busy | (start & (op <= 3'd3)));
    assign dout     = rd_sel ? r_lo : r_hi;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: directed vector table, hand-written
// corner sequences and randomized operations against a 64-bit arithmetic model.
module tb_md_unit_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        rd_sel;
    logic        md_use;
    logic        busy;
    logic        md_stall;
    logic [31:0] dout;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .rd_sel   (rd_sel),
        .md_use   (md_use),
        .busy     (busy),
        .md_stall (md_stall),
        .dout     (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        int          cyc;
        logic        use_md;
    } vec_t;

    vec_t tbl [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic rd(output logic [31:0] h, output logic [31:0] l);
        rd_sel = 1'b0;
        #1 h = dout;
        rd_sel = 1'b1;
        #1 l = dout;
    endtask

    // Reference model: HI/LO effect of one accepted operation, from the
    // arithmetic definitions using 64-bit integers.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] hi, inout logic [31:0] lo, output int cyc);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        cyc = 0;
        case (o)
            3'd0: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; cyc = 5; end
            3'd1: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; cyc = 5; end
            3'd2: begin
                cyc = 10;
                if (b != 32'd0) begin sq = sa / sb; sr = sa % sb; lo = sq[31:0]; hi = sr[31:0]; end
            end
            3'd3: begin
                cyc = 10;
                if (b != 32'd0) begin uq = ua / ub; ur = ua % ub; lo = uq[31:0]; hi = ur[31:0]; end
            end
            3'd4: hi = a;
            3'd5: lo = a;
            default: cyc = 0;
        endcase
    endtask

    // Issue one operation from IDLE and check stall, busy length and result.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int ecyc,
                         input logic use_md, input string nm);
        int n;
        logic [31:0] h, l;
        md_use = use_md;
        start  = 1'b1;
        op     = o;
        A      = a;
        B      = b;
        #1;
        chk({nm, "_stall_acc"}, {31'd0, md_stall}, {31'd0, use_md & (o <= 3'd3)});
        tick();
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            if (use_md) chk({nm, "_stall_busy"}, {31'd0, md_stall}, 32'd1);
            n++;
            tick();
        end
        chk({nm, "_busy_cycles"}, n, ecyc);
        chk({nm, "_stall_after"}, {31'd0, md_stall}, 32'd0);
        rd(h, l);
        chk({nm, "_hi"}, h, eh);
        chk({nm, "_lo"}, l, el);
        md_use = 1'b0;
    endtask

    initial begin
        logic [31:0] h, l, eh, el;
        int n, ecyc;
        logic [2:0] o;
        logic [31:0] a, b;

        reset = 1'b1; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
        rd_sel = 1'b0; md_use = 1'b0;
        tick(); tick();
        reset = 1'b0;
        md_use = 1'b1;
        tick();
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_stall", {31'd0, md_stall}, 32'd0);
        rd(h, l);
        chk("reset_hi", h, 32'd0);
        chk("reset_lo", l, 32'd0);
        md_use = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;

        tbl[0] = '{3'd0, 32'hFFFF_FFFF, 32'd2,           32'hFFFF_FFFF, 32'hFFFF_FFFE, 5,  1'b0};
        tbl[1] = '{3'd1, 32'hFFFF_FFFF, 32'd2,           32'h0000_0001, 32'hFFFF_FFFE, 5,  1'b1};
        tbl[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,           32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0};
        tbl[3] = '{3'd3, 32'd7,         32'd2,           32'h0000_0001, 32'h0000_0003, 10, 1'b0};
        tbl[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF,   32'h0000_0000, 32'h8000_0000, 10, 1'b0};
        tbl[5] = '{3'd4, 32'h1234_5678, 32'd0,           32'h1234_5678, 32'h8000_0000, 0,  1'b1};
        tbl[6] = '{3'd3, 32'd5,         32'd0,           32'h1234_5678, 32'h8000_0000, 10, 1'b1};
        tbl[7] = '{3'd5, 32'hCAFE_F00D, 32'd0,           32'h1234_5678, 32'hCAFE_F00D, 0,  1'b0};
        tbl[8] = '{3'd6, 32'hDEAD_BEEF, 32'd1,           32'h1234_5678, 32'hCAFE_F00D, 0,  1'b1};
        tbl[9] = '{3'd7, 32'hDEAD_BEEF, 32'd1,           32'h1234_5678, 32'hCAFE_F00D, 0,  1'b0};

        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].eh, tbl[i].el, tbl[i].cyc,
                  tbl[i].use_md, $sformatf("vec%0d", i));
        end
        m_hi = 32'h1234_5678; m_lo = 32'hCAFE_F00D;

        // MTLO issued while a MULT is in flight must be ignored
        start = 1'b1; op = 3'd0; A = 32'd3; B = 32'hFFFF_FFFE;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; op = 3'd5; A = 32'hAAAA_5555;
        tick();
        start = 1'b0;
        n = 2;
        while (busy === 1'b1 && n < 200) begin n++; tick(); end
        chk("mtlo_ign_cycles", n, 5);
        rd(h, l);
        chk("mtlo_ign_hi", h, 32'hFFFF_FFFF);
        chk("mtlo_ign_lo", l, 32'hFFFF_FFFA);

        // Reset in the middle of a MULT discards the pending result
        start = 1'b1; op = 3'd0; A = 32'd5; B = 32'd7;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        rd(h, l);
        chk("rst_mid_hi", h, 32'd0);
        chk("rst_mid_lo", l, 32'd0);
        repeat (8) tick();
        chk("rst_late_busy", {31'd0, busy}, 32'd0);
        rd(h, l);
        chk("rst_late_hi", h, 32'd0);
        chk("rst_late_lo", l, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;

        // Back-to-back: second op issued in the gap cycle after busy falls
        do_op(3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5, 1'b1, "b2b_first");
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5, 1'b1, "b2b_second");
        m_hi = 32'hFFFF_FFFE; m_lo = 32'h0000_0001;

        // Randomized operations against the reference model
        for (int k = 0; k < 40; k++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
            eh = m_hi; el = m_lo;
            model(o, a, b, eh, el, ecyc);
            do_op(o, a, b, eh, el, ecyc, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", k));
            m_hi = eh; m_lo = el;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
